// File: rtl/mccpu_bus.sv
// mccpu_bus -- memory/peripheral bus for the multi-cycle CPU core.
//
// Decodes the core's byte address into a word RAM and a 32-byte MMIO window.
// Reads are combinational, so the core never stalls. Writes commit on the
// next rising clock edge.
//
// MMIO window, at offset from MMIO_BASE:
//   0x00 LED   RW   [15:0] drives led_o
//   0x04 SW    RO   sw_i after a 2-flop synchroniser
//   0x08 CNT   RW   32-bit timer counter
//   0x0C CMP   RW   32-bit compare value
//   0x10 CTRL  RW   bit0 EN, bit1 AUTO (reload on match), bit2 IEN
//   0x14 STAT  W1C  bit0 MATCH
//   0x18/0x1C reserved: read 0, writes ignored
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous reset, active-low
//   MemWrite   write strobe from the core
//   adr        byte address from the core (adr[1:0] ignored)
//   writedata  store data from the core
//   readdata   combinational read data for adr
//   sw_i       asynchronous board switches
//   led_o      LED register contents
//   irq_o      timer interrupt (MATCH & IEN)
//   bus_err    sticky flag, set by a write to an unmapped address
module mccpu_bus #(
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWrite,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [15:0] sw_i,
    output logic [15:0] led_o,
    output logic        irq_o,
    output logic        bus_err
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    typedef enum logic [2:0] {
        OFF_LED  = 3'd0,
        OFF_SW   = 3'd1,
        OFF_CNT  = 3'd2,
        OFF_CMP  = 3'd3,
        OFF_CTRL = 3'd4,
        OFF_STAT = 3'd5
    } mmio_off_t;

    logic [31:0] mem [RAM_WORDS];

    logic [15:0] led_q;
    logic [15:0] sw_s1;
    logic [15:0] sw_s2;
    logic [31:0] cnt;
    logic [31:0] cmp;
    logic        en;
    logic        auto_rl;
    logic        ien;
    logic        match;

    logic        ram_hit;
    logic        mmio_hit;
    logic [2:0]  off;
    logic [AW-1:0] ram_idx;

    logic        wr_led;
    logic        wr_cnt;
    logic        wr_cmp;
    logic        wr_ctrl;
    logic        wr_stat;
    logic        wr_bad;
    logic        match_hit;

    // Address decode
    always_comb begin
        ram_hit  = (adr < RAM_BYTES);
        mmio_hit = (adr >= MMIO_BASE) && (adr < (MMIO_BASE + 32'h20));
        off      = adr[4:2];
        ram_idx  = adr[AW+1:2];
    end

    always_comb begin
        wr_led  = MemWrite && mmio_hit && (off == OFF_LED);
        wr_cnt  = MemWrite && mmio_hit && (off == OFF_CNT);
        wr_cmp  = MemWrite && mmio_hit && (off == OFF_CMP);
        wr_ctrl = MemWrite && mmio_hit && (off == OFF_CTRL);
        wr_stat = MemWrite && mmio_hit && (off == OFF_STAT);
        wr_bad  = MemWrite && !ram_hit && !mmio_hit;
    end

    // Match is judged on the counter value before any same-cycle core write.
    assign match_hit = en && (cnt == cmp);

    // Word RAM: contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit) begin
            mem[ram_idx] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q   <= '0;
            sw_s1   <= '0;
            sw_s2   <= '0;
            cnt     <= '0;
            cmp     <= '0;
            en      <= 1'b0;
            auto_rl <= 1'b0;
            ien     <= 1'b0;
            match   <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            sw_s1 <= sw_i;
            sw_s2 <= sw_s1;

            if (wr_led) begin
                led_q <= writedata[15:0];
            end
            if (wr_cmp) begin
                cmp <= writedata;
            end
            if (wr_bad) begin
                bus_err <= 1'b1;
            end

            // Timer step. The core writes further down override these
            // assignments, which gives them priority over the hardware.
            if (en) begin
                if (cnt == cmp) begin
                    if (auto_rl) begin
                        cnt <= '0;
                    end else begin
                        en <= 1'b0;
                    end
                end else begin
                    cnt <= cnt + 32'd1;
                end
            end
            if (wr_cnt) begin
                cnt <= writedata;
            end
            if (wr_ctrl) begin
                en      <= writedata[0];
                auto_rl <= writedata[1];
                ien     <= writedata[2];
            end

            // W1C first, then the set, so a same-cycle match wins.
            if (wr_stat && writedata[0]) begin
                match <= 1'b0;
            end
            if (match_hit) begin
                match <= 1'b1;
            end
        end
    end

    always_comb begin
        readdata = '0;
        if (ram_hit) begin
            readdata = mem[ram_idx];
        end else if (mmio_hit) begin
            case (off)
                OFF_LED:  readdata = {16'h0000, led_q};
                OFF_SW:   readdata = {16'h0000, sw_s2};
                OFF_CNT:  readdata = cnt;
                OFF_CMP:  readdata = cmp;
                OFF_CTRL: readdata = {29'd0, ien, auto_rl, en};
                OFF_STAT: readdata = {31'd0, match};
                default:  readdata = '0;
            endcase
        end
    end

    assign led_o = led_q;
    assign irq_o = match & ien;

endmodule

// File: tb/tb_mccpu_bus.sv
module tb_mccpu_bus;

    localparam logic [31:0] MB   = 32'h0000_7F00;
    localparam logic [31:0] A_LED  = MB + 32'h00;
    localparam logic [31:0] A_SW   = MB + 32'h04;
    localparam logic [31:0] A_CNT  = MB + 32'h08;
    localparam logic [31:0] A_CMP  = MB + 32'h0C;
    localparam logic [31:0] A_CTRL = MB + 32'h10;
    localparam logic [31:0] A_STAT = MB + 32'h14;
    localparam logic [31:0] A_RSV  = MB + 32'h18;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] sw_i;
    logic [15:0] led_o;
    logic        irq_o;
    logic        bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    logic [31:0] ram_model [int];

    mccpu_bus #(
        .RAM_WORDS(1024),
        .MMIO_BASE(32'h0000_7F00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .MemWrite(MemWrite),
        .adr(adr),
        .writedata(writedata),
        .readdata(readdata),
        .sw_i(sw_i),
        .led_o(led_o),
        .irq_o(irq_o),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // Push the expectation, let the combinational read settle, pop and compare.
    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        sb_entry_t e;
        sb.push_back('{tag, exp});
        MemWrite = 1'b0;
        adr = a;
        #1;
        e = sb.pop_front();
        check_eq(e.tag, readdata, e.exp);
    endtask

    task automatic pins(input logic [15:0] led, input logic irq, input logic err, input string tag);
        sb_entry_t e;
        sb.push_back('{{tag, ".led"}, {16'h0, led}});
        sb.push_back('{{tag, ".irq"}, {31'h0, irq}});
        sb.push_back('{{tag, ".err"}, {31'h0, err}});
        #1;
        e = sb.pop_front(); check_eq(e.tag, {16'h0, led_o}, e.exp);
        e = sb.pop_front(); check_eq(e.tag, {31'h0, irq_o}, e.exp);
        e = sb.pop_front(); check_eq(e.tag, {31'h0, bus_err}, e.exp);
    endtask

    // Drive a write; it commits on the next rising edge, and we return 1 ns later.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        adr = a;
        writedata = d;
        MemWrite = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned idx;

        rst = 1'b0;
        MemWrite = 1'b0;
        adr = '0;
        writedata = '0;
        sw_i = 16'hFFFF;

        // Reset state with switches held high
        tick(3);
        pins(16'h0, 1'b0, 1'b0, "reset");
        rd(A_SW, 32'h0, "reset.sw");
        rd(A_CNT, 32'h0, "reset.cnt");
        @(negedge clk);
        rst = 1'b1;
        sw_i = 16'h0000;
        tick(3);

        // RAM: random words, including the first and last word
        for (int i = 0; i < 8; i++) begin
            idx = (i == 0) ? 0 : (i == 1) ? 1023 : $urandom_range(1023);
            ram_model[int'(idx)] = $urandom;
            wr(idx << 2, ram_model[int'(idx)]);
        end
        wr(32'h14, 32'h1111_1111); ram_model[5] = 32'h1111_1111;
        wr(32'h10, 32'hDEAD_BEEF); ram_model[4] = 32'hDEAD_BEEF;
        rd(32'h10, 32'hDEAD_BEEF, "ram.0x10");
        rd(32'h13, 32'hDEAD_BEEF, "ram.0x13");
        rd(32'h14, 32'h1111_1111, "ram.0x14");
        foreach (ram_model[k]) begin
            rd(32'(k) << 2, ram_model[k], $sformatf("ram.w%0d", k));
            tick(1);
        end

        // LED and unmapped / reserved reads
        wr(A_LED, 32'h1234_ABCD);
        pins(16'hABCD, 1'b0, 1'b0, "led");
        rd(A_LED, 32'h0000_ABCD, "led.rb");
        wr(A_RSV, 32'hFFFF_FFFF);
        rd(A_RSV, 32'h0, "rsv.rd");
        pins(16'hABCD, 1'b0, 1'b0, "rsv.noerr");
        wr(A_SW, 32'hFFFF_FFFF);
        rd(32'h0000_7EFC, 32'h0, "unmapped.lo");
        rd(32'h0000_7F20, 32'h0, "unmapped.hi");

        // Switch synchroniser latency
        sw_i = 16'h00A5;
        rd(A_SW, 32'h0, "sw.0clk");
        tick(1);
        rd(A_SW, 32'h0, "sw.1clk");
        tick(1);
        rd(A_SW, 32'h0000_00A5, "sw.2clk");

        // One-shot timer
        wr(A_CMP, 32'd5);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'h5);
        rd(A_CNT, 32'd0, "os.cnt0");
        tick(5);
        rd(A_CNT, 32'd5, "os.cnt5");
        rd(A_STAT, 32'd0, "os.nomatch");
        pins(16'hABCD, 1'b0, 1'b0, "os.pre");
        tick(1);
        rd(A_STAT, 32'd1, "os.match");
        pins(16'hABCD, 1'b1, 1'b0, "os.irq");
        tick(2);
        rd(A_CNT, 32'd5, "os.hold");
        rd(A_CTRL, 32'h4, "os.en_clr");
        wr(A_STAT, 32'h1);
        pins(16'hABCD, 1'b0, 1'b0, "os.w1c");
        rd(A_STAT, 32'd0, "os.stat_clr");

        // Auto-reload across the 32-bit wrap
        wr(A_CMP, 32'd1);
        wr(A_CNT, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'h3);
        rd(A_CNT, 32'hFFFF_FFFE, "ar.c0");
        tick(1); rd(A_CNT, 32'hFFFF_FFFF, "ar.c1");
        tick(1); rd(A_CNT, 32'h0, "ar.c2");
        tick(1); rd(A_CNT, 32'h1, "ar.c3");
        tick(1); rd(A_CNT, 32'h0, "ar.c4");
        rd(A_STAT, 32'd1, "ar.match");
        rd(A_CTRL, 32'h3, "ar.en_kept");
        pins(16'hABCD, 1'b0, 1'b0, "ar.noirq");
        // cnt=0: clear takes effect
        wr(A_STAT, 32'h1);
        rd(A_STAT, 32'd0, "ar.clr");
        rd(A_CNT, 32'h1, "ar.c5");
        // cnt==cmp now: same-cycle set wins over the clear
        wr(A_STAT, 32'h1);
        rd(A_STAT, 32'd1, "ar.set_wins");
        rd(A_CNT, 32'h0, "ar.c6");

        // Unmapped write: sticky error, no aliasing into RAM or MMIO
        wr(32'h0001_0000, 32'hCAFE_F00D);
        pins(16'hABCD, 1'b0, 1'b1, "err.set");
        rd(32'h0, ram_model[0], "err.ram0");
        rd(32'h0001_0000, 32'h0, "err.rd");
        tick(2);
        pins(16'hABCD, 1'b0, 1'b1, "err.sticky");

        // Asynchronous reset while the timer runs with IRQ pending
        wr(A_CMP, 32'd2);
        wr(A_CNT, 32'd0);
        wr(A_CTRL, 32'h7);
        tick(3);
        pins(16'hABCD, 1'b1, 1'b1, "rst.pre");
        rst = 1'b0;
        pins(16'h0, 1'b0, 1'b0, "rst.async");
        rd(A_CNT, 32'h0, "rst.cnt");
        rd(A_CTRL, 32'h0, "rst.ctrl");
        rd(A_CMP, 32'h0, "rst.cmp");
        @(negedge clk);
        rst = 1'b1;
        tick(3);
        rd(A_CNT, 32'h0, "rst.idle");
        rd(A_STAT, 32'h0, "rst.stat");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
